// File: rtl/bnode.sv
// Compare-exchange cell for the bitonic sorter: orders a packed key pair,
// optionally through a single output register.
module bnode #(
    parameter int DATA_WIDTH = 8,
    parameter bit DESCENDING = 1'b0,
    parameter bit SIGNED     = 1'b0,
    parameter bit REGISTERED = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*DATA_WIDTH-1:0] data_in,
    output logic [2*DATA_WIDTH-1:0] data_out,
    output logic                    swapped
);

    logic [DATA_WIDTH-1:0]   key_a;
    logic [DATA_WIDTH-1:0]   key_b;
    logic                    a_gt_b;
    logic                    a_lt_b;
    logic                    swap_d;
    logic [2*DATA_WIDTH-1:0] pair_d;

    assign key_a = data_in[2*DATA_WIDTH-1:DATA_WIDTH];
    assign key_b = data_in[DATA_WIDTH-1:0];

    always_comb begin
        a_gt_b = 1'b0;
        a_lt_b = 1'b0;
        if (SIGNED) begin
            a_gt_b = $signed(key_a) > $signed(key_b);
            a_lt_b = $signed(key_a) < $signed(key_b);
        end else begin
            a_gt_b = key_a > key_b;
            a_lt_b = key_a < key_b;
        end
    end

    // Strict compares keep equal keys in place, so ties never swap.
    always_comb begin
        swap_d = DESCENDING ? a_gt_b : a_lt_b;
        pair_d = swap_d ? {key_b, key_a} : {key_a, key_b};
    end

    if (REGISTERED) begin : g_reg
        logic [2*DATA_WIDTH-1:0] data_out_q;
        logic                    swapped_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                data_out_q <= '0;
                swapped_q  <= 1'b0;
            end else begin
                data_out_q <= pair_d;
                swapped_q  <= swap_d;
            end
        end

        assign data_out = data_out_q;
        assign swapped  = swapped_q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ reset;
        assign data_out       = pair_d;
        assign swapped        = swap_d;
    end

endmodule

// File: tb/tb_bnode.sv
// Self-checking bench for bnode: directed vectors, registered sequence,
// and randomized pairs against an ordering model.
module tb_bnode;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic [15:0] rdin;

    logic [15:0] o_asc, o_sgn, o_dsc, o_reg, o_rds;
    logic        s_asc, s_sgn, s_dsc, s_reg, s_rds;

    int checks;
    int failures;

    bnode #(.DATA_WIDTH(8)) u_asc (
        .clk(clk), .reset(reset), .data_in(din),
        .data_out(o_asc), .swapped(s_asc)
    );
    bnode #(.DATA_WIDTH(8), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .reset(reset), .data_in(din),
        .data_out(o_sgn), .swapped(s_sgn)
    );
    bnode #(.DATA_WIDTH(8), .DESCENDING(1'b1)) u_dsc (
        .clk(clk), .reset(reset), .data_in(din),
        .data_out(o_dsc), .swapped(s_dsc)
    );
    bnode #(.DATA_WIDTH(8), .REGISTERED(1'b1)) u_reg (
        .clk(clk), .reset(reset), .data_in(rdin),
        .data_out(o_reg), .swapped(s_reg)
    );
    bnode #(.DATA_WIDTH(8), .REGISTERED(1'b1), .DESCENDING(1'b1),
            .SIGNED(1'b1)) u_rds (
        .clk(clk), .reset(reset), .data_in(rdin),
        .data_out(o_rds), .swapped(s_rds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret each key as a number, decide which key belongs
    // on top, and swap only when the upper key is strictly on the wrong side.
    function automatic logic [16:0] model(logic [15:0] d, bit desc, bit sgn);
        int ka;
        int kb;
        bit s;
        if (sgn) begin
            ka = int'($signed(d[15:8]));
            kb = int'($signed(d[7:0]));
        end else begin
            ka = int'({24'd0, d[15:8]});
            kb = int'({24'd0, d[7:0]});
        end
        s = desc ? (ka > kb) : (ka < kb);
        return {s, s ? {d[7:0], d[15:8]} : d};
    endfunction

    task automatic chk(string name, logic [15:0] got, logic gs,
                       logic [15:0] exp, logic es);
        checks++;
        if (got !== exp || gs !== es) begin
            failures++;
            $display("FAIL %s: got data_out=%h swapped=%b, want %h/%b",
                     name, got, gs, exp, es);
        end
    endtask

    typedef struct {
        int          inst;
        logic [15:0] d;
        logic [15:0] q;
        logic        s;
    } vec_t;

    vec_t vt[9];

    task automatic pick(int inst, output logic [15:0] o, output logic s);
        case (inst)
            0: begin o = o_asc; s = s_asc; end
            1: begin o = o_sgn; s = s_sgn; end
            default: begin o = o_dsc; s = s_dsc; end
        endcase
    endtask

    task automatic reg_step(string name, logic [15:0] d, bit rst,
                            logic [15:0] eq, logic es);
        logic [15:0] hold_o;
        logic        hold_s;
        @(negedge clk);
        hold_o = o_reg;
        hold_s = s_reg;
        rdin  = d;
        reset = rst;
        #1;
        chk({name, "_hold"}, o_reg, s_reg, hold_o, hold_s);
        @(posedge clk);
        #1;
        chk(name, o_reg, s_reg, eq, es);
    endtask

    initial begin
        logic [15:0] go;
        logic        gs;
        logic [16:0] m;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        din      = 16'h0000;
        rdin     = 16'h0000;

        vt[0] = '{0, 16'h0307, 16'h0703, 1'b1};
        vt[1] = '{0, 16'hF010, 16'hF010, 1'b0};
        vt[2] = '{0, 16'h5555, 16'h5555, 1'b0};
        vt[3] = '{0, 16'h00FF, 16'hFF00, 1'b1};
        vt[4] = '{1, 16'h00FF, 16'h00FF, 1'b0};
        vt[5] = '{1, 16'h807F, 16'h7F80, 1'b1};
        vt[6] = '{2, 16'h0703, 16'h0307, 1'b1};
        vt[7] = '{2, 16'h5555, 16'h5555, 1'b0};
        vt[8] = '{2, 16'h00FF, 16'h00FF, 1'b0};

        for (int i = 0; i < 9; i++) begin
            din = vt[i].d;
            #1;
            pick(vt[i].inst, go, gs);
            chk($sformatf("vec%0d", i), go, gs, vt[i].q, vt[i].s);
        end

        for (int i = 0; i < 1000; i++) begin
            din = 16'($urandom);
            #1;
            m = model(din, 1'b0, 1'b0);
            chk("rnd_asc", o_asc, s_asc, m[15:0], m[16]);
            m = model(din, 1'b0, 1'b1);
            chk("rnd_sgn", o_sgn, s_sgn, m[15:0], m[16]);
            m = model(din, 1'b1, 1'b0);
            chk("rnd_dsc", o_dsc, s_dsc, m[15:0], m[16]);
        end

        @(negedge clk);
        chk("reg_reset", o_reg, s_reg, 16'h0000, 1'b0);
        chk("rds_reset", o_rds, s_rds, 16'h0000, 1'b0);

        reg_step("reg_p0", 16'h0102, 1'b0, 16'h0201, 1'b1);
        reg_step("reg_p1", 16'h0904, 1'b0, 16'h0904, 1'b0);
        reg_step("reg_p2", 16'h2030, 1'b0, 16'h3020, 1'b1);
        reg_step("reg_rst", 16'h4455, 1'b1, 16'h0000, 1'b0);
        reg_step("reg_post", 16'h0102, 1'b0, 16'h0201, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rdin = 16'($urandom);
            @(posedge clk);
            #1;
            m = model(rdin, 1'b0, 1'b0);
            chk("rnd_reg", o_reg, s_reg, m[15:0], m[16]);
            m = model(rdin, 1'b1, 1'b1);
            chk("rnd_rds", o_rds, s_rds, m[15:0], m[16]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
